// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
//   OP_*     : 3-bit opcode encodings presented on op
//   state_t  : control FSM encoding (idle / iterating / result held)
package alu_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : load operands and perform the first step on this edge
//   a_i, b_i   : multiplicand / multiplier, sampled only with start_i
//   done_o     : the step taken on the coming edge is the last one
//   prod_o     : accumulator value after the coming edge (full 2*WIDTH product when done_o)
module alu_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d, step_src;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     upper;

  // The first step happens on the start edge itself, so the full product
  // is available after WIDTH edges with the multiplier in the low half.
  always_comb begin
    step_src = start_i ? {{WIDTH{1'b0}}, b_i} : acc_q;
    mcand_d  = start_i ? a_i : mcand_q;
    upper    = {1'b0, step_src[2*WIDTH-1:WIDTH]}
             + ({1'b0, mcand_d} & {(WIDTH+1){step_src[0]}});
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d = {upper, step_src[WIDTH-1:1]};
      cnt_d = CW'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      acc_d = {upper, step_src[WIDTH-1:1]};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CW'(1));
  assign prod_o = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready operand and result handshakes.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake (ready only when idle)
//   op, a, b              : opcode and operands, captured on acceptance
//   out_valid/out_ready   : result handshake
//   result, cout, zout    : registered result, carry-style flag, zero flag
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    W_CNT = CW'(WIDTH);
  localparam logic [WIDTH-1:0] W_B   = WIDTH'(WIDTH);

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   sh_q, sh_d, sh_src, sh_step;
  logic [CW-1:0]      shcnt_q, shcnt_d, n;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               sh_left, sh_out, mul_start, mul_done;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] mul_prod;

  assign n    = (b >= W_B) ? W_CNT : b[CW-1:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // One shifter serves both the first step (taken on the accept edge from a)
  // and every later step (from the working register).
  always_comb begin
    sh_src  = (state_q == ST_IDLE) ? a : sh_q;
    sh_left = (state_q == ST_IDLE) ? (op == OP_SHL) : (op_q == OP_SHL);
    sh_step = sh_left ? {sh_src[WIDTH-2:0], 1'b0} : {1'b0, sh_src[WIDTH-1:1]};
    sh_out  = sh_left ? sh_src[WIDTH-1] : sh_src[0];
  end

  assign mul_start = in_valid && (state_q == ST_IDLE) && (op == OP_MUL);

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sh_d     = sh_q;
    shcnt_d  = shcnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          state_d = ST_DONE;
          case (op)
            OP_PASS: begin result_d = a;        cout_d = 1'b0; end
            OP_NOR:  begin result_d = ~(a | b); cout_d = 1'b0; end
            OP_ADD:  {cout_d, result_d} = sum;
            OP_SUB:  {cout_d, result_d} = diff;
            OP_SHL, OP_SHR: begin
              if (n == '0) begin
                result_d = a;
                cout_d   = 1'b0;
              end else if (n == CW'(1)) begin
                result_d = sh_step;
                cout_d   = sh_out;
              end else begin
                sh_d    = sh_step;
                shcnt_d = n - CW'(1);
                state_d = ST_BUSY;
              end
            end
            OP_MUL:  state_d = ST_BUSY;
            default: begin result_d = '0; cout_d = 1'b0; end
          endcase
        end
      end
      ST_BUSY: begin
        if (op_q == OP_MUL) begin
          if (mul_done) begin
            result_d = mul_prod[WIDTH-1:0];
            cout_d   = |mul_prod[2*WIDTH-1:WIDTH];
            state_d  = ST_DONE;
          end
        end else begin
          sh_d    = sh_step;
          shcnt_d = shcnt_q - CW'(1);
          if (shcnt_q == CW'(1)) begin
            result_d = sh_step;
            cout_d   = sh_out;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_PASS;
      sh_q     <= '0;
      shcnt_q  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      shcnt_q  <= shcnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign zout      = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH = 8): vector table with a
// scoreboard queue, backpressure holds, and a reset-abort sequence.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, cout, zout;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zout      (zout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    int           lat;
    int           hold;
    logic         early;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    int           lat;
  } exp_t;

  localparam int NV = 22;
  vec_t vecs [NV];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    chk({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    op        = v.op;
    a         = v.a;
    b         = v.b;
    out_ready = v.early;
    e.res = v.res; e.c = v.c; e.z = v.z; e.lat = v.lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid) seen = 1;
      else begin
        // operands and in_valid wiggle while busy; none of it may matter
        a        = 8'($urandom);
        b        = 8'($urandom);
        op       = 3'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: no out_valid within 40 cycles, expected latency %0d", tag, e.lat);
      out_ready = 1'b0;
      return;
    end
    chk({tag, " latency"}, 32'(cyc),    32'(e.lat));
    chk({tag, " result"},  32'(result), 32'(e.res));
    chk({tag, " cout"},    32'(cout),   32'(e.c));
    chk({tag, " zout"},    32'(zout),   32'(e.z));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " held in_ready"},  32'(in_ready),  32'd0);
      chk({tag, " held result"},    32'(result),    32'(e.res));
      chk({tag, " held zout"},      32'(zout),      32'(e.z));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " out_valid after hs"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after hs"},  32'(in_ready),  32'd1);
    chk({tag, " result kept"},        32'(result),    32'(e.res));
    chk({tag, " cout kept"},          32'(cout),      32'(e.c));
    out_ready = 1'b0;
  endtask

  initial begin
    //          op       a      b      res    c     z     L  hold early
    vecs[0]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1, 0, 1'b1};
    vecs[1]  = '{OP_SUB,  8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1, 0, 1'b0};
    vecs[2]  = '{OP_SHL,  8'hC1, 8'h02, 8'h04, 1'b1, 1'b0, 2, 0, 1'b0};
    vecs[3]  = '{OP_SHR,  8'h81, 8'h09, 8'h00, 1'b1, 1'b1, 8, 0, 1'b0};
    vecs[4]  = '{OP_MUL,  8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 8, 2, 1'b0};
    vecs[5]  = '{OP_MUL,  8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 8, 0, 1'b1};
    vecs[6]  = '{OP_NOR,  8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1, 5, 1'b0};
    vecs[7]  = '{OP_PASS, 8'h5A, 8'h33, 8'h5A, 1'b0, 1'b0, 1, 0, 1'b0};
    vecs[8]  = '{OP_ZERO, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 0, 1'b0};
    vecs[9]  = '{OP_SHL,  8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1, 0, 1'b0};
    vecs[10] = '{OP_SHR,  8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1, 0, 1'b0};
    vecs[11] = '{OP_SHL,  8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1, 0, 1'b0};
    vecs[12] = '{OP_SHL,  8'h81, 8'h08, 8'h00, 1'b1, 1'b1, 8, 0, 1'b0};
    vecs[13] = '{OP_SHR,  8'h6C, 8'h03, 8'h0D, 1'b1, 1'b0, 3, 0, 1'b0};
    vecs[14] = '{OP_SHL,  8'h6C, 8'h03, 8'h60, 1'b1, 1'b0, 3, 1, 1'b0};
    vecs[15] = '{OP_MUL,  8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 8, 0, 1'b0};
    vecs[16] = '{OP_MUL,  8'h00, 8'h37, 8'h00, 1'b0, 1'b1, 8, 0, 1'b0};
    vecs[17] = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1, 0, 1'b0};
    vecs[18] = '{OP_SUB,  8'h07, 8'h07, 8'h00, 1'b0, 1'b1, 1, 0, 1'b0};
    vecs[19] = '{OP_SHR,  8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 7, 0, 1'b0};
    vecs[20] = '{OP_SHL,  8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 8, 0, 1'b0};
    vecs[21] = '{OP_SUB,  8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1, 0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready",  32'(in_ready),  32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result",    32'(result),    32'd0);
    chk("reset cout",      32'(cout),      32'd0);
    chk("reset zout",      32'(zout),      32'd1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a MUL: the operation must vanish entirely.
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; a = 8'h0F; b = 8'h11; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstmul busy out_valid c%0d", c), 32'(out_valid), 32'd0);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rstmul during rst out_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rstmul in_ready",  32'(in_ready), 32'd1);
    chk("rstmul result",    32'(result),   32'd0);
    chk("rstmul cout",      32'(cout),     32'd0);
    chk("rstmul zout",      32'(zout),     32'd1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("rstmul no out_valid c%0d", c), 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    run_vec(vecs[5], "post-rst mul");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
